// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one uart_tx among byte producers.
// A grant lasts until the client's last byte, MAX_BURST bytes, or IDLE_TMO stalled cycles.
module uart_tx_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TMO  = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_CLIENTS-1:0]   cli_valid,
  input  logic [8*N_CLIENTS-1:0] cli_data,
  input  logic [N_CLIENTS-1:0]   cli_last,
  output logic [N_CLIENTS-1:0]   cli_ack,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_ready,
  output logic [N_CLIENTS-1:0]   grant,
  output logic                   busy
);
  localparam int IW = $clog2(N_CLIENTS);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(IDLE_TMO + 1);
  typedef enum logic [2:0] {ARB, SEND, WBUSY, WDONE, REL} state_t;
  state_t               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d, g_q, g_d, win;
  logic [N_CLIENTS-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [7:0]           data_q, data_d, burst_q, burst_d;
  logic [CW-1:0]        idle_q, idle_d;
  logic                 last_q, last_d, start_q, start_d, busy_q, found;
  logic [PW-1:0]        cand;
  // Round-robin search starting just after the previous owner
  always_comb begin
    win = rr_ptr_q;
    found = 1'b0;
    cand = '0;
    for (int i = 1; i <= N_CLIENTS; i++) begin
      cand = {1'b0, rr_ptr_q} + PW'(i);
      cand = (cand >= PW'(N_CLIENTS)) ? cand - PW'(N_CLIENTS) : cand;
      if (!found && cli_valid[cand[IW-1:0]]) begin
        win = cand[IW-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;
    grant_d  = grant_q;
    data_d   = data_q;
    burst_d  = burst_q;
    idle_d   = idle_q;
    last_d   = last_q;
    start_d  = 1'b0;
    ack_d    = '0;
    case (state_q)
      ARB: if (found) begin
        g_d     = win;
        grant_d = N_CLIENTS'(1) << win;
        burst_d = '0;
        idle_d  = '0;
        state_d = SEND;
      end
      SEND: if (cli_valid[g_q] && tx_ready) begin
        data_d  = cli_data[{g_q, 3'b000} +: 8];
        last_d  = cli_last[g_q];
        burst_d = burst_q + 8'd1;
        idle_d  = '0;
        start_d = 1'b1;
        ack_d   = grant_q;
        state_d = WBUSY;
      end else if (!cli_valid[g_q]) begin
        idle_d  = idle_q + CW'(1);
        state_d = (idle_q == CW'(IDLE_TMO - 1)) ? REL : SEND;
      end
      WBUSY: state_d = tx_ready ? WBUSY : WDONE;
      WDONE: if (tx_ready) state_d = (last_q || burst_q == 8'(MAX_BURST)) ? REL : SEND;
      REL: begin
        rr_ptr_d = g_q;
        grant_d  = '0;
        state_d  = ARB;
      end
      default: state_d = ARB;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ARB;
      rr_ptr_q <= IW'(N_CLIENTS - 1);
      g_q      <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      data_q   <= '0;
      burst_q  <= '0;
      idle_q   <= '0;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      burst_q  <= burst_d;
      idle_q   <= idle_d;
      last_q   <= last_d;
      start_q  <= start_d;
      busy_q   <= state_d != ARB;
    end
  end
  assign cli_ack  = ack_q;
  assign tx_data  = data_q;
  assign tx_start = start_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios checked against a packet-level arbitration model
// and a per-cycle protocol checker, with a 10-cycle uart_tx ready model.
module tb_uart_tx_arbiter;
  localparam int N = 4, MB = 16, TMO = 1024;
  logic           clk = 1'b0, rstn = 1'b0;
  logic [N-1:0]   cli_valid = '0, cli_last = '0, cli_ack, grant, oh;
  logic [8*N-1:0] cli_data = '0;
  logic [7:0]     tx_data, held = '0;
  logic           tx_start, busy, tx_ready = 1'b1, hold = 1'b0, seen_low = 1'b0, prev_rstn = 1'b0;
  logic [8:0]     mem [N][64];
  int             head [N], tail [N];
  logic [7:0]     exp_b[$], obs_b[$];
  int             exp_c[$], obs_c[$];
  int checks = 0, failures = 0, model_rr = N - 1, ucnt = 0, run = 0, max_stall = 0, n_start = 0, n_ack = 0, t = 0;

  uart_tx_arbiter #(.N_CLIENTS(N), .MAX_BURST(MB), .IDLE_TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .cli_valid(cli_valid), .cli_data(cli_data), .cli_last(cli_last),
    .cli_ack(cli_ack), .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b, input bit last);
    mem[k][tail[k]] = {last, b};
    tail[k]++;
  endtask

  // Packet-level model: owner = next client after rr with data; it sends until last,
  // MAX_BURST bytes, or its queue runs dry; then rr moves to it.
  task automatic plan();
    int h [N];
    int rr, g, n;
    bit found, lst;
    for (int i = 0; i < N; i++) h[i] = head[i];
    rr = model_rr;
    forever begin
      found = 0;
      g = 0;
      for (int i = 1; i <= N; i++)
        if (!found && h[(rr + i) % N] < tail[(rr + i) % N]) begin
          found = 1;
          g = (rr + i) % N;
        end
      if (!found) break;
      n = 0;
      do begin
        exp_b.push_back(mem[g][h[g]][7:0]);
        exp_c.push_back(g);
        lst = mem[g][h[g]][8];
        h[g]++;
        n++;
      end while (!lst && n < MB && h[g] < tail[g]);
      rr = g;
    end
    model_rr = rr;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int k = 0; k < N; k++) tail[k] = 0;
    model_rr = N - 1;
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, input string name);
    int w = 0;
    while (obs_b.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk(obs_b.size() >= n, name, obs_b.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((exp_b.size() != 0 || busy) && w < budget);
    chk(exp_b.size() == 0 && !busy, name, exp_b.size(), 0);
  endtask

  // Clients and uart_tx model: react just after the negedge
  initial forever begin
    @(negedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (!rstn) head[k] = 0;
      else if (cli_ack[k] && head[k] < tail[k]) head[k]++;
      cli_valid[k] = head[k] < tail[k];
      cli_data[8*k +: 8] = mem[k][head[k]][7:0];
      cli_last[k] = mem[k][head[k]][8];
    end
    if (!rstn) begin
      tx_ready = 1'b1;
      ucnt = 0;
    end else if (tx_start) begin
      tx_ready = 1'b0;
      ucnt = 10;
    end else if (!tx_ready) begin
      ucnt--;
      if (ucnt == 0) tx_ready = 1'b1;
    end
  end

  // Per-cycle checker against the model's expected byte stream
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      if (prev_rstn) begin
        exp_b.delete();
        exp_c.delete();
        obs_b.delete();
        obs_c.delete();
        max_stall = 0;
      end
      hold = 1'b0;
      seen_low = 1'b0;
      run = 0;
    end else begin
      chk($onehot0(grant), "grant_onehot0", int'(grant), 1);
      chk(busy == (grant != '0), "busy_vs_grant", int'(busy), int'(grant != '0));
      n_ack += $countones(cli_ack);
      if (tx_start) begin
        n_start++;
        chk(!hold, "start_during_byte", int'(hold), 0);
        chk(exp_b.size() > 0, "unexpected_start", int'(tx_data), -1);
        if (exp_b.size() > 0) begin
          oh = '0;
          oh[exp_c[0]] = 1'b1;
          chk(tx_data == exp_b[0], "tx_data", int'(tx_data), int'(exp_b[0]));
          chk(cli_ack == oh, "cli_ack", int'(cli_ack), int'(oh));
          chk(grant == oh, "grant_at_start", int'(grant), int'(oh));
          void'(exp_b.pop_front());
          void'(exp_c.pop_front());
        end
        obs_b.push_back(tx_data);
        obs_c.push_back($clog2(int'(grant)));
        hold = 1'b1;
        seen_low = 1'b0;
        held = tx_data;
      end else begin
        chk(cli_ack == '0, "ack_without_start", int'(cli_ack), 0);
        if (hold) begin
          chk(tx_data == held, "tx_data_stable", int'(tx_data), int'(held));
          if (!tx_ready) seen_low = 1'b1;
          else if (seen_low) hold = 1'b0;
        end
      end
      run = (grant == 4'b1000 && tx_ready && !tx_start && !cli_valid[3]) ? run + 1 : 0;
      if (run > max_stall) max_stall = run;
    end
    prev_rstn = rstn;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: "Hi" from client 0, then rr_ptr=0 makes client 1 win a tie
    @(negedge clk);
    #2;
    do_reset();
    push(0, 8'h48, 0);
    push(0, 8'h69, 1);
    plan();
    release_rst();
    wait_obs(1, 50, "t1_first_start");
    chk(grant == 4'b0001, "t1_grant", int'(grant), 1);
    wait_idle(200, "t1_idle");
    chk(grant == 4'b0000, "t1_grant_released", int'(grant), 0);
    chk(obs_b.size() == 2, "t1_acks", obs_b.size(), 2);
    chk(obs_b[0] == 8'h48, "t1_byte0", int'(obs_b[0]), 8'h48);
    chk(obs_b[1] == 8'h69, "t1_byte1", int'(obs_b[1]), 8'h69);
    push(0, 8'h4A, 1);
    push(1, 8'h4B, 1);
    plan();
    chk(exp_c[0] == 1, "t1_model_rr", exp_c[0], 1);
    wait_idle(300, "t1b_idle");
    chk(obs_c[2] == 1, "t1_rr_after_release", obs_c[2], 1);
    chk(obs_c[3] == 0, "t1_then_client0", obs_c[3], 0);
    // 2: all four valid from reset, two rounds
    @(negedge clk);
    #2;
    do_reset();
    for (int k = 0; k < N; k++) push(k, 8'h41 + 8'(k), 1);
    plan();
    chk(exp_c[0] == 0 && exp_c[3] == 3, "t2_model_order", exp_c[3], 3);
    release_rst();
    wait_idle(300, "t2_round1");
    for (int k = 0; k < N; k++) push(k, 8'h61 + 8'(k), 1);
    plan();
    wait_idle(300, "t2_round2");
    chk(obs_b[0] == 8'h41, "t2_first_A", int'(obs_b[0]), 8'h41);
    chk(obs_b[3] == 8'h44, "t2_fourth_D", int'(obs_b[3]), 8'h44);
    chk(obs_c[4] == 0 && obs_b[4] == 8'h61, "t2_round2_client0", obs_c[4], 0);
    // 3: 40-byte stream on client 1 split by MAX_BURST, client 2 slips in
    @(negedge clk);
    #2;
    do_reset();
    for (int i = 0; i < 40; i++) push(1, 8'h80 + 8'(i), 0);
    push(2, 8'h71, 0);
    push(2, 8'h72, 1);
    plan();
    chk(exp_c[15] == 1 && exp_c[16] == 2 && exp_b[18] == 8'h90, "t3_model_split", exp_c[16], 2);
    release_rst();
    wait_idle(5000, "t3_idle");
    chk(obs_b.size() == 42, "t3_byte_count", obs_b.size(), 42);
    chk(obs_c[16] == 2 && obs_b[16] == 8'h71, "t3_client2_after_burst", obs_c[16], 2);
    chk(obs_c[18] == 1 && obs_b[18] == 8'h90, "t3_resume_byte17", int'(obs_b[18]), 8'h90);
    chk(obs_b[41] == 8'hA7, "t3_last_byte", int'(obs_b[41]), 8'hA7);
    // 4: client 3 stalls mid-packet; idle timeout hands the UART to client 0
    @(negedge clk);
    #2;
    do_reset();
    push(3, 8'h58, 0);
    plan();
    release_rst();
    wait_obs(1, 50, "t4_first_start");
    repeat (2) @(negedge clk);
    push(0, 8'h50, 1);
    plan();
    chk(exp_c[0] == 0, "t4_model_next", exp_c[0], 0);
    wait_idle(3000, "t4_idle");
    chk(max_stall == TMO + 1, "t4_stall_cycles", max_stall, TMO + 1);
    chk(obs_c[1] == 0 && obs_b[1] == 8'h50, "t4_client0_next", obs_c[1], 0);
    // 6: async reset while waiting for the UART to finish a byte
    @(negedge clk);
    #2;
    do_reset();
    push(2, 8'h78, 0);
    push(2, 8'h79, 0);
    push(2, 8'h7A, 1);
    plan();
    release_rst();
    wait_obs(1, 50, "t6_first_start");
    t = 0;
    while (tx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(!tx_ready && busy && tx_data == 8'h78, "t6_in_wdone", int'(tx_data), 8'h78);
    #3 rstn = 1'b0;
    #1;
    chk(tx_start == 1'b0 && cli_ack == '0, "t6_rst_start_ack", int'(cli_ack), 0);
    chk(tx_data == 8'h00, "t6_rst_tx_data", int'(tx_data), 0);
    chk(grant == '0 && busy == 1'b0, "t6_rst_grant_busy", int'(grant), 0);
    do_reset();
    push(2, 8'h4E, 1);
    push(0, 8'h4D, 1);
    plan();
    release_rst();
    wait_idle(300, "t6_idle");
    chk(obs_c[0] == 0 && obs_b[0] == 8'h4D, "t6_client0_first", obs_c[0], 0);
    // 5: pulse/ack pairing over the whole run
    chk(n_start == n_ack && n_start > 0, "t5_ack_per_start", n_ack, n_start);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
